// File: rtl/mux_2x1_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_arbiter_if
// Brief    : Request/grant/data bundle between two requesters and the arbiter.
//            The lock signal exists only when MUX_ARB_LOCK_EN is defined.
// Revision : 1.0
// ============================================================================
interface mux_2x1_arbiter_if;
    logic req0;
    logic req1;
    logic d0;
    logic d1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic o;
    logic o_valid;
`ifdef MUX_ARB_LOCK_EN
    logic lock;

    modport master (
        output req0, req1, d0, d1, lock,
        input  gnt0, gnt1, sel, o, o_valid
    );
    modport slave (
        input  req0, req1, d0, d1, lock,
        output gnt0, gnt1, sel, o, o_valid
    );
`else
    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, sel, o, o_valid
    );
    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, sel, o, o_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mux_2x1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_2x1_arbiter (with leaf mux_2x1)
// Brief    : Round-robin arbiter with hold limit in front of a 2:1 mux; output
//            data registered with a valid flag. Optional MUX_ARB_LOCK_EN adds
//            a lock input that suppresses the hold-limit handoff.
// Revision : 1.0
// ============================================================================
module mux_2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux_2x1_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    mux_2x1_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(MAX_HOLD - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_hold_cnt_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_sel;
    logic               r_o;
    logic               r_o_valid;
    logic               w_lock;
    logic               w_hold_sat;
    logic               w_mux_y;

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = bus.lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_hold_sat = (r_hold_cnt == c_hold_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_last     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_last     <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = '0;
        w_last_nxt     = r_last;
        case (r_state)
            IDLE: begin
                if (bus.req0 && bus.req1) w_state_nxt = r_last ? GNT0 : GNT1;
                else if (bus.req0)        w_state_nxt = GNT0;
                else if (bus.req1)        w_state_nxt = GNT1;
            end
            GNT0: begin
                if (!bus.req0)                                 w_state_nxt = bus.req1 ? GNT1 : IDLE;
                else if (bus.req1 && w_hold_sat && !w_lock)    w_state_nxt = GNT1;
            end
            GNT1: begin
                if (!bus.req1)                                 w_state_nxt = bus.req0 ? GNT0 : IDLE;
                else if (bus.req0 && w_hold_sat && !w_lock)    w_state_nxt = GNT0;
            end
            default: w_state_nxt = IDLE;
        endcase

        // A fresh grant restarts the tenure; a held grant counts up and saturates.
        if (w_state_nxt != r_state) begin
            if (w_state_nxt == GNT0)      w_last_nxt = 1'b0;
            else if (w_state_nxt == GNT1) w_last_nxt = 1'b1;
        end else if (r_state != IDLE) begin
            w_hold_cnt_nxt = w_hold_sat ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
    end

    mux_2x1 u_mux (
        .a (bus.d0),
        .b (bus.d1),
        .s (r_sel),
        .y (w_mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_sel     <= 1'b0;
            r_o       <= 1'b0;
            r_o_valid <= 1'b0;
        end else begin
            r_gnt0    <= (w_state_nxt == GNT0);
            r_gnt1    <= (w_state_nxt == GNT1);
            r_sel     <= (w_state_nxt == GNT1);
            r_o_valid <= r_gnt0 | r_gnt1;
            r_o       <= (r_gnt0 | r_gnt1) & w_mux_y;
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.sel     = r_sel;
    assign bus.o       = r_o;
    assign bus.o_valid = r_o_valid;
endmodule
`default_nettype wire

// File: tb/tb_mux_2x1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2x1_arbiter
// Brief    : Directed + random bench against a grant-tenure reference model.
//            Lock scenarios are exercised when MUX_ARB_LOCK_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_mux_2x1_arbiter;
    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 3;

    logic clk;
    logic rst;
    logic m_lock;
    int   checks;
    int   errors;

    // Reference state: who holds the grant (-1 none), for how many cycles,
    // who won most recently, and the expected registered data outputs.
    int   holder;
    int   tenure;
    int   last_w;
    logic exp_o;
    logic exp_v;

    mux_2x1_arbiter_if bus ();

`ifdef MUX_ARB_LOCK_EN
    assign bus.lock = m_lock;
`endif

    mux_2x1_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gnt0"},    bus.gnt0,    logic'(holder == 0));
        check({tag, ".gnt1"},    bus.gnt1,    logic'(holder == 1));
        check({tag, ".sel"},     bus.sel,     logic'(holder == 1));
        check({tag, ".o"},       bus.o,       exp_o);
        check({tag, ".o_valid"}, bus.o_valid, exp_v);
    endtask

    task automatic model_reset();
        holder = -1;
        tenure = 0;
        last_w = 1;
        exp_o  = 1'b0;
        exp_v  = 1'b0;
    endtask

    task automatic model_edge(input logic r0, input logic r1, input logic dd0, input logic dd1);
        logic [1:0] rq;
        logic [1:0] dd;
        int nh;
        int other;
        rq = {r1, r0};
        dd = {dd1, dd0};
        exp_v = (holder >= 0);
        exp_o = (holder >= 0) ? dd[holder] : 1'b0;
        if (holder < 0) begin
            if (rq == 2'b11)  nh = (last_w == 1) ? 0 : 1;
            else if (rq[0])   nh = 0;
            else if (rq[1])   nh = 1;
            else              nh = -1;
        end else begin
            other = 1 - holder;
            if (!rq[holder])                                      nh = rq[other] ? other : -1;
            else if (rq[other] && tenure >= MAX_HOLD && !m_lock)  nh = other;
            else                                                  nh = holder;
        end
        if (nh >= 0 && nh != holder) begin
            tenure = 1;
            last_w = nh;
        end else if (nh >= 0) begin
            tenure++;
        end
        holder = nh;
    endtask

    task automatic cycle(input logic r0, input logic r1, input logic dd0, input logic dd1, input string tag);
        bus.req0 = r0;
        bus.req1 = r1;
        bus.d0   = dd0;
        bus.d1   = dd1;
        @(posedge clk);
        model_edge(r0, r1, dd0, dd1);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic r0;
        logic r1;
        checks   = 0;
        errors   = 0;
        m_lock   = 1'b0;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d0   = 1'b0;
        bus.d1   = 1'b0;

        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), "idle");

        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'($urandom), "single0");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "single0_drop");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "single0_tail");

        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), "tie");

        // Early release at the second tenure cycle, then a fresh tie from idle.
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, "early_a");
        cycle(1'b1, 1'b1, 1'b1, 1'b0, "early_b");
        cycle(1'b0, 1'b1, 1'b0, 1'b1, "early_release");
        cycle(1'b0, 1'b1, 1'b0, 1'b1, "early_hold1");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "early_idle");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "early_idle2");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, "early_tie");

        // Asynchronous reset while requester 1 holds the grant.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), "pre_rst");
        check("pre_rst_in_gnt1", bus.gnt1, 1'b1);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("rst_async");
        #1 rst = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, "post_rst_tie");

`ifdef MUX_ARB_LOCK_EN
        do_reset();
        m_lock = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), "lock_hold");
        m_lock = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, "lock_fall");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, "lock_after");
`endif

        do_reset();
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
`ifdef MUX_ARB_LOCK_EN
            if ($urandom_range(7) == 0) m_lock = ~m_lock;
`endif
            cycle(r0, r1, 1'($urandom), 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
